// File: rtl/reqrsp_isolate_limiter.sv
// -----------------------------------------------------------------------------
// reqrsp_isolate_limiter
//   Sits upstream of the isochronous reqrsp crossing in the source clock
//   domain. Forwards reqrsp traffic while bounding the number of outstanding
//   requests. When isolation is requested, it stops accepting new requests and
//   drains in-flight responses. Once drained, it flags isolated_o so the
//   downstream domain can be clock-gated or reset safely.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   isolate_i      request isolation (level)
//   src_req_i      upstream request        (q_valid, q, p_ready)
//   src_rsp_o      upstream response       (q_ready, p_valid, p)
//   dst_req_o      downstream request      (to the crossing)
//   dst_rsp_i      downstream response
//   isolated_o     registered: drained and gated
//   outstanding_o  current outstanding request count
//   err_o          registered one-cycle pulse: response with zero outstanding
// -----------------------------------------------------------------------------
package reqrsp_isolate_limiter_pkg;
   typedef struct packed {
      logic        q_valid;
      logic [31:0] q;
      logic        p_ready;
   } req_t;

   typedef struct packed {
      logic        q_ready;
      logic        p_valid;
      logic [31:0] p;
   } rsp_t;
endpackage

module reqrsp_isolate_limiter #(
   parameter int unsigned MaxOutstanding = 4,
   parameter type         req_t          = reqrsp_isolate_limiter_pkg::req_t,
   parameter type         rsp_t          = reqrsp_isolate_limiter_pkg::rsp_t,
   localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            isolate_i,
   input  req_t            src_req_i,
   output rsp_t            src_rsp_o,
   output req_t            dst_req_o,
   input  rsp_t            dst_rsp_i,
   output logic            isolated_o,
   output logic [CntW-1:0] outstanding_o,
   output logic            err_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } state_e;

   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            q_pending_q, q_pending_d;
   logic            isolated_q, isolated_d;
   logic            err_q, err_d;

   logic            open_gate;
   logic            pass_q;
   logic            q_hs;
   logic            p_hs;

   // A request already presented downstream stays visible until accepted,
   // even if the gate closes underneath it.
   assign open_gate = (state_q == RUN) && (cnt_q < MaxCnt);
   assign pass_q    = open_gate | q_pending_q;

   always_comb begin
      dst_req_o         = src_req_i;
      dst_req_o.q_valid = src_req_i.q_valid & pass_q;
      src_rsp_o         = dst_rsp_i;
      src_rsp_o.q_ready = dst_rsp_i.q_ready & pass_q;
   end

   assign q_hs = dst_req_o.q_valid & dst_rsp_i.q_ready;
   assign p_hs = dst_rsp_i.p_valid & src_req_i.p_ready;

   always_comb begin
      cnt_d       = cnt_q;
      err_d       = 1'b0;
      q_pending_d = q_pending_q;
      state_d     = state_q;

      if (q_hs) begin
         q_pending_d = 1'b0;
      end else if (dst_req_o.q_valid) begin
         q_pending_d = 1'b1;
      end

      if (q_hs && !p_hs) begin
         cnt_d = cnt_q + 1'b1;
      end else if (p_hs && !q_hs) begin
         // Spurious response: saturate at zero and flag it.
         if (cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      unique case (state_q)
         RUN: begin
            if (isolate_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!isolate_i) begin
               state_d = RUN;
            end else if ((cnt_d == '0) && !q_pending_q) begin
               state_d = ISOLATED;
            end
         end
         ISOLATED: begin
            if (!isolate_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      isolated_d = (state_d == ISOLATED);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         q_pending_q <= 1'b0;
         isolated_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         q_pending_q <= q_pending_d;
         isolated_q  <= isolated_d;
         err_q       <= err_d;
      end
   end

   assign isolated_o    = isolated_q;
   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_reqrsp_isolate_limiter.sv
// -----------------------------------------------------------------------------
// tb_reqrsp_isolate_limiter
//   Directed bench for reqrsp_isolate_limiter (MaxOutstanding = 4). Request and
//   response payloads are pushed to scoreboard queues when driven and popped
//   and compared when the corresponding handshake completes. Counter, isolation
//   and error outputs are compared against hand-derived cycle expectations.
// -----------------------------------------------------------------------------
module tb_reqrsp_isolate_limiter;
   import reqrsp_isolate_limiter_pkg::*;

   localparam int unsigned Max  = 4;
   localparam int unsigned CntW = $clog2(Max + 1);

   logic            clk;
   logic            rst;
   logic            isolate;
   req_t            src_req;
   rsp_t            src_rsp;
   req_t            dst_req;
   rsp_t            dst_rsp;
   logic            isolated;
   logic [CntW-1:0] outstanding;
   logic            err;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q_fifo[$];
   logic [31:0] exp_p_fifo[$];
   logic [31:0] next_q = 32'h1000_0000;
   logic [31:0] next_p = 32'hA000_0000;

   reqrsp_isolate_limiter #(
      .MaxOutstanding(Max)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .isolate_i    (isolate),
      .src_req_i    (src_req),
      .src_rsp_o    (src_rsp),
      .dst_req_o    (dst_req),
      .dst_rsp_i    (dst_rsp),
      .isolated_o   (isolated),
      .outstanding_o(outstanding),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic present_req();
      src_req.q_valid = 1'b1;
      src_req.q       = next_q;
      exp_q_fifo.push_back(next_q);
      next_q          = next_q + 32'h11;
   endtask

   task automatic drive_rsp();
      dst_rsp.p_valid = 1'b1;
      dst_rsp.p       = next_p;
      exp_p_fifo.push_back(next_p);
      next_p          = next_p + 32'h7;
   endtask

   // Scoreboard side: compare payloads on completed handshakes.
   always @(negedge clk) begin
      if (!rst) begin
         if (dst_req.q_valid && dst_rsp.q_ready) begin
            if (exp_q_fifo.size() == 0) begin
               chk("q_unexpected", 32'(dst_req.q), 32'hFFFF_FFFF);
            end else begin
               chk("q_payload", 32'(dst_req.q), exp_q_fifo.pop_front());
            end
         end
         if (src_rsp.p_valid && dst_req.p_ready) begin
            if (exp_p_fifo.size() == 0) begin
               chk("p_unexpected", 32'(src_rsp.p), 32'hFFFF_FFFF);
            end else begin
               chk("p_payload", 32'(src_rsp.p), exp_p_fifo.pop_front());
            end
         end
      end
   end

   initial begin
      rst             = 1'b1;
      isolate         = 1'b0;
      src_req         = '0;
      src_req.p_ready = 1'b1;
      dst_rsp         = '0;

      repeat (2) cyc();
      #1;
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_isolated", 32'(isolated), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // Fill to the limit: first four requests go straight through.
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (i == 0) rst = 1'b0;
         dst_rsp.q_ready = 1'b1;
         present_req();
         #1;
         chk("fill_dst_valid", 32'(dst_req.q_valid), 32'd1);
      end
      // c4, c5: fifth request blocked at the limit.
      for (int i = 0; i < 2; i++) begin
         cyc();
         if (i == 0) present_req();
         #1;
         chk("full_outstanding", 32'(outstanding), 32'd4);
         chk("full_src_ready", 32'(src_rsp.q_ready), 32'd0);
         chk("full_dst_valid", 32'(dst_req.q_valid), 32'd0);
      end
      // c6: one response returns.
      cyc();
      drive_rsp();
      #1;
      chk("rsp_passthrough", 32'(src_rsp.p_valid), 32'd1);
      chk("rsp_outstanding", 32'(outstanding), 32'd4);
      // c7: count drops, held request goes through.
      cyc();
      dst_rsp.p_valid = 1'b0;
      #1;
      chk("after_rsp_outstanding", 32'(outstanding), 32'd3);
      chk("reopen_src_ready", 32'(src_rsp.q_ready), 32'd1);
      // c8, c9: two responses.
      cyc();
      src_req.q_valid = 1'b0;
      drive_rsp();
      #1;
      chk("refill_outstanding", 32'(outstanding), 32'd4);
      cyc();
      drive_rsp();
      // c10: simultaneous request and response with cnt=2.
      cyc();
      present_req();
      drive_rsp();
      #1;
      chk("both_pre_outstanding", 32'(outstanding), 32'd2);
      // c11: raise isolate, nothing in flight on the request side.
      cyc();
      src_req.q_valid = 1'b0;
      dst_rsp.p_valid = 1'b0;
      isolate         = 1'b1;
      #1;
      chk("both_outstanding", 32'(outstanding), 32'd2);
      chk("both_err", 32'(err), 32'd0);
      // c12..c16: drain with two responses spread over five cycles.
      cyc();
      present_req();
      drive_rsp();
      #1;
      chk("drain_block_c12", 32'(dst_req.q_valid), 32'd0);
      chk("drain_isolated_c12", 32'(isolated), 32'd0);
      cyc();
      dst_rsp.p_valid = 1'b0;
      #1;
      chk("drain_block_c13", 32'(dst_req.q_valid), 32'd0);
      chk("drain_outstanding_c13", 32'(outstanding), 32'd1);
      cyc();
      #1;
      chk("drain_block_c14", 32'(dst_req.q_valid), 32'd0);
      cyc();
      drive_rsp();
      #1;
      chk("drain_isolated_c15", 32'(isolated), 32'd0);
      chk("drain_outstanding_c15", 32'(outstanding), 32'd1);
      cyc();
      dst_rsp.p_valid = 1'b0;
      #1;
      chk("isolated_c16", 32'(isolated), 32'd1);
      chk("isolated_outstanding", 32'(outstanding), 32'd0);
      chk("isolated_block", 32'(dst_req.q_valid), 32'd0);
      // c17: drop isolate; still isolated this cycle.
      cyc();
      isolate = 1'b0;
      #1;
      chk("release_c17_isolated", 32'(isolated), 32'd1);
      chk("release_c17_block", 32'(dst_req.q_valid), 32'd0);
      // c18: back in RUN, held request accepted.
      cyc();
      #1;
      chk("release_c18_isolated", 32'(isolated), 32'd0);
      chk("release_c18_dst_valid", 32'(dst_req.q_valid), 32'd1);
      // c19: present with downstream stalled.
      cyc();
      dst_rsp.q_ready = 1'b0;
      present_req();
      #1;
      chk("stall_outstanding", 32'(outstanding), 32'd1);
      chk("stall_dst_valid", 32'(dst_req.q_valid), 32'd1);
      chk("stall_src_ready", 32'(src_rsp.q_ready), 32'd0);
      // c20: isolate while the request is pending.
      cyc();
      isolate = 1'b1;
      #1;
      chk("pend_c20_dst_valid", 32'(dst_req.q_valid), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         #1;
         chk("pend_drain_dst_valid", 32'(dst_req.q_valid), 32'd1);
         chk("pend_drain_isolated", 32'(isolated), 32'd0);
      end
      // c23: downstream accepts the pending request.
      cyc();
      dst_rsp.q_ready = 1'b1;
      #1;
      chk("pend_accept_src_ready", 32'(src_rsp.q_ready), 32'd1);
      // c24, c25: return both outstanding responses.
      cyc();
      src_req.q_valid = 1'b0;
      drive_rsp();
      #1;
      chk("pend_counted", 32'(outstanding), 32'd2);
      cyc();
      drive_rsp();
      #1;
      chk("pend_outstanding_c25", 32'(outstanding), 32'd1);
      chk("pend_isolated_c25", 32'(isolated), 32'd0);
      // c26: drained.
      cyc();
      dst_rsp.p_valid = 1'b0;
      isolate         = 1'b0;
      #1;
      chk("pend_isolated_c26", 32'(isolated), 32'd1);
      chk("pend_outstanding_c26", 32'(outstanding), 32'd0);
      // c27: spurious response with nothing outstanding.
      cyc();
      drive_rsp();
      #1;
      chk("spur_isolated", 32'(isolated), 32'd0);
      chk("spur_err_pre", 32'(err), 32'd0);
      cyc();
      dst_rsp.p_valid = 1'b0;
      #1;
      chk("spur_err", 32'(err), 32'd1);
      chk("spur_outstanding", 32'(outstanding), 32'd0);
      // c29..c31: three requests, then reset mid-operation.
      for (int i = 0; i < 3; i++) begin
         cyc();
         present_req();
         #1;
         if (i == 0) chk("spur_err_clear", 32'(err), 32'd0);
      end
      cyc();
      src_req.q_valid = 1'b0;
      rst             = 1'b1;
      #1;
      chk("prerst_outstanding", 32'(outstanding), 32'd3);
      cyc();
      rst = 1'b0;
      present_req();
      #1;
      chk("midrst_outstanding", 32'(outstanding), 32'd0);
      chk("midrst_isolated", 32'(isolated), 32'd0);
      chk("midrst_run", 32'(dst_req.q_valid), 32'd1);
      cyc();
      src_req.q_valid = 1'b0;
      #1;
      chk("postrst_outstanding", 32'(outstanding), 32'd1);

      repeat (2) cyc();
      chk("q_fifo_empty", 32'(exp_q_fifo.size()), 32'd0);
      chk("p_fifo_empty", 32'(exp_p_fifo.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
